uart_tx_arbiter: RTL
====================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares one UART frame transmitter among N_REQ requesters with round-robin arbitration.
//  Wraps the granted requester's byte into a 10-bit frame {stop=1, data, start=0}.
//  Pulses tx_enable to the transmitter and tracks tx_active to detect completion.
//  Returns a per-requester ack on completion, or err if the transmitter never starts.
//  Sits between the protocol/requester logic and the tx serializer.
// PARAMETERS
//  N_REQ          4   number of requesters (2..8)
//  DATA_W         8   payload bits per frame; frame width = DATA_W+2
//  START_TIMEOUT  16  cycles after tx_enable to wait for tx_active before abort (>=2)
// PORTS
//  tx_Clk     in   1              system clock, all logic on posedge
//  tx_Rst     in   1              synchronous, active-high reset
//  req        in   N_REQ          level request; bit i = requester i
//  req_data   in   N_REQ*DATA_W   payload; slice [i*DATA_W +: DATA_W] = requester i
//  req_ack    out  N_REQ          one-cycle pulse: requester i's frame finished
//  req_err    out  N_REQ          one-cycle pulse: requester i's frame aborted on timeout
//  grant_id   out  $clog2(N_REQ)  index of current/last granted requester
//  busy       out  1              high in every state except IDLE
//  i_tx_byte  out  DATA_W+2       frame to transmitter, LSB sent first (start bit)
//  tx_enable  out  1              one-cycle launch pulse to transmitter
//  tx_active  in   1              transmitter busy, high while a frame is on the line
// BEHAVIOUR
//  Reset:
//   - Outputs: req_ack=0, req_err=0, tx_enable=0, busy=0, grant_id=0, i_tx_byte=0.
//   - Internal: state=IDLE, rr pointer last=N_REQ-1, timer=0.
//   - Reset mid-transfer abandons it; no ack/err is issued; tx_enable is not re-pulsed.
//  FSM IDLE -> LAUNCH -> WAIT_START -> WAIT_DONE -> IDLE:
//   - IDLE: if |req and tx_active==0, grant first set bit searching last+1, last+2, ...
//     modulo N_REQ. Register grant_id and last=grant.
//     Latch i_tx_byte={1'b1, req_data[g], 1'b0}. Go to LAUNCH.
//     If tx_active==1 (stale/foreign frame), stay in IDLE; no grant.
//   - LAUNCH: tx_enable=1 for exactly this cycle; timer<=0; go to WAIT_START.
//   - WAIT_START: if tx_active==1, go to WAIT_DONE.
//     Else timer++; when timer==START_TIMEOUT-1, pulse req_err[grant_id] and go to IDLE.
//   - WAIT_DONE: when tx_active==0, pulse req_ack[grant_id] and go to IDLE.
//  Latency and arbitration:
//   - req sampled in IDLE at edge t -> tx_enable high during cycle t+1.
//   - ack/err pulse during the cycle the FSM returns to IDLE.
//   - Next grant is earliest one cycle later, so back-to-back frames have >=2 idle cycles.
//  Frame stability:
//   - i_tx_byte and grant_id are held constant from latch until the next grant.
//   - req_data changes after the grant are ignored.
//  Handshake rules:
//   - Requester holds req until its ack/err; dropping req mid-transfer does not abort.
//   - A req still high after ack is re-eligible, but round-robin serves others first.
//   - Only one of req_ack/req_err is ever set, and only the bit for grant_id.
//  Pointer wrap: after granting N_REQ-1, the search resumes at 0.
//  Timeout: an err frame still advances the pointer, so a stuck requester cannot starve others.
// TESTING
//  1. Reset then req=4'b0001, data0=8'hA5 -> tx_enable 1 cycle later with i_tx_byte=10'b1_10100101_0.
//     Model tx_active high for 10 cycles -> req_ack=4'b0001 pulse.
//  2. req=4'b1111 held -> grant order 0,1,2,3,0; each gets exactly one ack;
//     grant_id never repeats consecutively.
//  3. tx_active held 0 after tx_enable, START_TIMEOUT=16 ->
//     req_err[g] pulse 16 cycles after tx_enable; no ack; pointer advances.
//  4. tx_active=1 in IDLE with req=4'b0010 -> no tx_enable until tx_active falls;
//     grant 1 launches the next cycle.
//  5. Assert tx_Rst during WAIT_DONE -> all outputs 0 the next cycle; no ack;
//     after release, req=4'b0001 grants requester 0.
//  6. Change req_data[0] from 8'h3C to 8'hFF after the grant -> i_tx_byte stays {1,8'h3C,0} until ack.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//
// Shares one UART frame transmitter among N_REQ requesters using round-robin
// arbitration. The granted requester's byte is wrapped into a frame
// {stop=1, data, start=0} and launched with a one-cycle tx_enable pulse. The
// transmitter's tx_active level is then tracked to detect the start and end of
// the frame. The requester receives req_ack when the frame finishes, or req_err
// if the transmitter never starts within START_TIMEOUT cycles.
//
// Handshake: a requester raises req[i] with its byte on its req_data slice and
// holds both until it sees req_ack[i] or req_err[i]. The byte is captured at
// grant time, so later changes to req_data are ignored. Dropping req after the
// grant does not abort the frame. Only one of req_ack/req_err pulses per grant,
// and only on the bit for grant_id.
//
// Ports
//   tx_Clk     in   1              clock, all logic on posedge
//   tx_Rst     in   1              synchronous active-high reset
//   req        in   N_REQ          level request per requester
//   req_data   in   N_REQ*DATA_W   payload, slice [i*DATA_W +: DATA_W] = requester i
//   req_ack    out  N_REQ          one-cycle pulse, frame finished
//   req_err    out  N_REQ          one-cycle pulse, frame aborted (no start)
//   grant_id   out  $clog2(N_REQ)  current/last granted requester
//   busy       out  1              high whenever the FSM is not IDLE
//   i_tx_byte  out  DATA_W+2       frame to transmitter, LSB (start bit) first
//   tx_enable  out  1              one-cycle launch pulse
//   tx_active  in   1              transmitter busy with a frame
//   state_dbg  out  2              current FSM state (debug visibility)
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int N_REQ         = 4,
    parameter int DATA_W        = 8,
    parameter int START_TIMEOUT = 16
) (
    input  logic                       tx_Clk,
    input  logic                       tx_Rst,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ*DATA_W-1:0]    req_data,
    output logic [N_REQ-1:0]           req_ack,
    output logic [N_REQ-1:0]           req_err,
    output logic [$clog2(N_REQ)-1:0]   grant_id,
    output logic                       busy,
    output logic [DATA_W+1:0]          i_tx_byte,
    output logic                       tx_enable,
    input  logic                       tx_active,
    output logic [1:0]                 state_dbg
);

    localparam int GW = $clog2(N_REQ);
    localparam int TW = $clog2(START_TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        LAUNCH     = 2'd1,
        WAIT_START = 2'd2,
        WAIT_DONE  = 2'd3
    } state_t;

    state_t          state;
    logic [GW-1:0]   last;
    logic [TW-1:0]   timer;

    logic            pick_valid;
    logic [GW-1:0]   pick;
    logic [DATA_W-1:0] pick_data;

    // Round-robin search starting at last+1. The loop walks from the farthest
    // candidate to the nearest so the nearest set bit is the final assignment.
    always_comb begin
        int idx;
        pick_valid = |req;
        pick       = '0;
        pick_data  = '0;
        idx        = 0;
        for (int k = N_REQ; k >= 1; k--) begin
            idx = (int'(last) + k) % N_REQ;
            if (req[idx]) begin
                pick      = GW'(idx);
                pick_data = req_data[idx*DATA_W +: DATA_W];
            end
        end
    end

    assign busy      = (state != IDLE);
    assign state_dbg = state;

    always_ff @(posedge tx_Clk) begin
        if (tx_Rst) begin
            state     <= IDLE;
            last      <= GW'(N_REQ - 1);
            timer     <= '0;
            grant_id  <= '0;
            i_tx_byte <= '0;
            tx_enable <= 1'b0;
            req_ack   <= '0;
            req_err   <= '0;
        end else begin
            tx_enable <= 1'b0;
            req_ack   <= '0;
            req_err   <= '0;
            case (state)
                IDLE: begin
                    // A frame already on the line (not ours) blocks new grants.
                    if (pick_valid && !tx_active) begin
                        grant_id  <= pick;
                        last      <= pick;
                        i_tx_byte <= {1'b1, pick_data, 1'b0};
                        tx_enable <= 1'b1;
                        state     <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    timer <= '0;
                    state <= WAIT_START;
                end
                WAIT_START: begin
                    if (tx_active) begin
                        state <= WAIT_DONE;
                    end else if (timer == TW'(START_TIMEOUT - 2)) begin
                        // Abort when the incremented count would reach
                        // START_TIMEOUT-1: err lands START_TIMEOUT cycles
                        // after the tx_enable cycle.
                        req_err <= N_REQ'(1) << grant_id;
                        state   <= IDLE;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                WAIT_DONE: begin
                    if (!tx_active) begin
                        req_ack <= N_REQ'(1) << grant_id;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
